// File: rtl/feed_forward_nn.sv
// Fixed-weight 3-stage pipelined classifier: 4 signed inputs, 3 ReLU hidden units, 2 step outputs.
// One vector accepted per clock; y0/y1 reflect the vector sampled two edges earlier.
module feed_forward_nn #(
  parameter int unsigned IN_W  = 9,
  parameter int unsigned ACC_W = 12
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic signed [IN_W-1:0] x0,
  input  logic signed [IN_W-1:0] x1,
  input  logic signed [IN_W-1:0] x2,
  input  logic signed [IN_W-1:0] x3,
  output logic                   y0,
  output logic                   y1
);

  // Stage 1: input register
  logic signed [IN_W-1:0] xr0_q, xr1_q, xr2_q, xr3_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      xr0_q <= '0;
      xr1_q <= '0;
      xr2_q <= '0;
      xr3_q <= '0;
    end else begin
      xr0_q <= x0;
      xr1_q <= x1;
      xr2_q <= x2;
      xr3_q <= x3;
    end
  end

  // Stage 2: hidden layer. Weights are +/-1, so products reduce to add/sub.
  logic signed [ACC_W-1:0] e0, e1, e2, e3;
  logic signed [ACC_W-1:0] s0, s1, s2;
  logic signed [ACC_W-1:0] h0_d, h1_d, h2_d;
  logic signed [ACC_W-1:0] h0_q, h1_q, h2_q;

  always_comb begin
    e0 = {{(ACC_W-IN_W){xr0_q[IN_W-1]}}, xr0_q};
    e1 = {{(ACC_W-IN_W){xr1_q[IN_W-1]}}, xr1_q};
    e2 = {{(ACC_W-IN_W){xr2_q[IN_W-1]}}, xr2_q};
    e3 = {{(ACC_W-IN_W){xr3_q[IN_W-1]}}, xr3_q};

    s0 = e0 - e2;
    s1 = e1 - e3;
    s2 = e2 + e3 - e0 - e1;

    // ReLU: a negative sum clamps to zero, zero passes through unchanged.
    h0_d = s0[ACC_W-1] ? '0 : s0;
    h1_d = s1[ACC_W-1] ? '0 : s1;
    h2_d = s2[ACC_W-1] ? '0 : s2;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      h0_q <= '0;
      h1_q <= '0;
      h2_q <= '0;
    end else begin
      h0_q <= h0_d;
      h1_q <= h1_d;
      h2_q <= h2_d;
    end
  end

  // Stage 3: output layer with strict step activation (a zero sum yields 0).
  logic signed [ACC_W-1:0] o0, o1;
  logic                    y0_d, y1_d;
  logic                    y0_q, y1_q;

  always_comb begin
    o0   = h0_q + h1_q - h2_q;
    o1   = h2_q - h0_q;
    y0_d = !o0[ACC_W-1] && (|o0);
    y1_d = !o1[ACC_W-1] && (|o1);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      y0_q <= 1'b0;
      y1_q <= 1'b0;
    end else begin
      y0_q <= y0_d;
      y1_q <= y1_d;
    end
  end

  assign y0 = y0_q;
  assign y1 = y1_q;

endmodule

// File: tb/tb_feed_forward_nn.sv
// Directed bench for feed_forward_nn: hand-computed vectors checked two edges after sampling.
module tb_feed_forward_nn;

  localparam int unsigned IN_W  = 9;
  localparam int unsigned ACC_W = 12;

  logic                   CLK;
  logic                   RST;
  logic signed [IN_W-1:0] x0, x1, x2, x3;
  logic                   y0, y1;

  int n_cmp;
  int n_err;

  feed_forward_nn #(
    .IN_W (IN_W),
    .ACC_W(ACC_W)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .x0 (x0),
    .x1 (x1),
    .x2 (x2),
    .x3 (x3),
    .y0 (y0),
    .y1 (y1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_x(input int a, input int b, input int c, input int d);
    x0 = IN_W'(a);
    x1 = IN_W'(b);
    x2 = IN_W'(c);
    x3 = IN_W'(d);
  endtask

  task automatic check(input string tag, input logic [1:0] exp);
    logic [1:0] got;
    got = {y0, y1};
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed y0y1=%b expected y0y1=%b", tag, got, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    RST   = 1'b0;
    set_x(-5, 100, 33, -200);

    // Held reset with arbitrary inputs
    #2;
    check("reset_hold_0", 2'b00);
    tick();
    check("reset_hold_1", 2'b00);
    set_x(196, 243, 106, 149);
    tick();
    check("reset_hold_2", 2'b00);
    #2;
    RST = 1'b1;

    // Back-to-back stream: A, B, tie, ext1, ext2, zeros
    set_x(196, 243, 106, 149);
    tick();
    check("fill_0", 2'b00);
    set_x(13, 37, 128, 160);
    tick();
    check("fill_1", 2'b00);
    set_x(77, 77, 77, 77);
    tick();
    check("vec_a", 2'b10);
    set_x(-256, -256, 255, 255);
    tick();
    check("vec_b", 2'b01);
    set_x(255, 255, -256, -256);
    tick();
    check("tie_77", 2'b00);
    set_x(0, 0, 0, 0);
    tick();
    check("extreme_neg_pos", 2'b01);
    tick();
    check("extreme_pos_neg", 2'b10);
    tick();
    check("all_zero", 2'b00);

    // Async reset mid-cycle drops outputs without a clock edge
    set_x(196, 243, 106, 149);
    tick();
    tick();
    tick();
    check("pre_async_a", 2'b10);
    #2;
    RST = 1'b0;
    #1;
    check("async_drop", 2'b00);
    #1;
    RST = 1'b1;
    tick();
    check("post_async_0", 2'b00);
    tick();
    check("post_async_1", 2'b00);
    tick();
    check("post_async_a", 2'b10);

    // Reset one cycle after A is sampled discards it
    set_x(0, 0, 0, 0);
    tick();
    tick();
    tick();
    check("drain_zero", 2'b00);
    set_x(196, 243, 106, 149);
    tick();
    set_x(0, 0, 0, 0);
    RST = 1'b0;
    #1;
    check("flight_rst_0", 2'b00);
    tick();
    check("flight_rst_1", 2'b00);
    RST = 1'b1;
    tick();
    check("flight_rst_2", 2'b00);
    tick();
    check("flight_rst_3", 2'b00);
    set_x(13, 37, 128, 160);
    tick();
    check("flight_rst_4", 2'b00);
    tick();
    check("flight_rst_5", 2'b00);
    tick();
    check("new_vec_b", 2'b01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
